apb_slave_mem: RTL and testbench
================================

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named PCLK and PRESETn.
REQ-002 The block SHALL take parameter ADDR_W, default 32, the PADDR width.
REQ-003 The block SHALL take parameter DATA_W, default 32, the PWDATA/PRDATA width.
REQ-004 The block SHALL take parameter DEPTH, default 64, the number of DATA_W-bit words.
REQ-005 The block SHALL take parameter WAIT_CYC, default 0, the wait states inserted per transfer (0..15).
REQ-006 PCLK  in  1  APB clock; all state changes on the rising edge.
REQ-007 PRESETn  in  1  asynchronous active-low reset.
REQ-008 PSEL  in  1  slave select.
REQ-009 PENABLE  in  1  access-phase indicator.
REQ-010 PWRITE  in  1  1 = write, 0 = read.
REQ-011 PADDR  in  ADDR_W  byte address.
REQ-012 PWDATA  in  DATA_W  write data.
REQ-013 PRDATA  out  DATA_W  read data, valid while PREADY=1 on a read.
REQ-014 PREADY  out  1  transfer-complete indication.
REQ-015 PSLVERR  out  1  error response, valid only while PREADY=1.

Function
REQ-016 The block SHALL use FSM states IDLE and ACCESS.
REQ-017 In IDLE with PSEL=1 and PENABLE=0 (setup phase), the block SHALL capture PADDR, PWRITE and PWDATA, load the wait counter with WAIT_CYC, and go to ACCESS next edge.
REQ-018 The block SHALL flag an address error when PADDR[1:0]!=0 or PADDR>=DEPTH*4, and SHALL latch the flag at the setup edge.
REQ-019 PREADY SHALL be combinational and equal (state==ACCESS && cnt==0 && PSEL && PENABLE).
REQ-020 With WAIT_CYC=0, the first access cycle SHALL complete, giving a 2-cycle transfer; with WAIT_CYC=N the transfer SHALL take N+2 cycles.
REQ-021 In ACCESS with cnt!=0, the block SHALL decrement cnt each cycle and hold PREADY=0.
REQ-022 On a read, the block SHALL register PRDATA from mem[PADDR>>2] at the setup edge and hold it until the next setup capture.
REQ-023 On an errored read, PRDATA SHALL be 0.
REQ-024 On a write, the block SHALL update mem at the edge where PSEL, PENABLE, PREADY and PWRITE are all 1 and the error flag is 0.
REQ-025 An errored write SHALL leave memory unchanged.
REQ-026 PSLVERR SHALL equal PREADY && error flag, and SHALL be 0 otherwise.
REQ-027 On completion (PREADY=1 edge), the block SHALL return to IDLE.
REQ-028 A setup phase on the cycle after completion (back-to-back) SHALL be accepted with no idle cycle lost.
REQ-029 If PSEL drops while in ACCESS before completion, the block SHALL abort to IDLE, write nothing and keep PREADY=0.
REQ-030 In IDLE, PENABLE=1 without a prior setup phase SHALL be ignored.
REQ-031 Captured address and data SHALL stay stable during wait states regardless of bus changes.

Reset
REQ-032 On PRESETn=0, the block SHALL immediately force state=IDLE, cnt=0, error flag=0, PRDATA=0, PREADY=0 and PSLVERR=0.
REQ-033 Reset SHALL NOT clear memory contents; reads before any write are undefined except on the reset-initialised bench.
REQ-034 Reset asserted mid-transfer SHALL abort that transfer with no memory write; operation SHALL resume on the first setup after PRESETn rises.

Structure
REQ-035 The shared package apb_slv_pkg SHALL hold the FSM state typedef (IDLE, ACCESS) and the default ADDR_W, DATA_W, DEPTH and WAIT_CYC constants.
REQ-036 Storage SHALL be a single sub-module, apb_slv_mem: DEPTH x DATA_W, synchronous write, one read port.
REQ-037 The FSM, wait counter, decode and error logic SHALL reside in apb_slave_mem.

Verification
REQ-038 WAIT_CYC=0: write 0xA5A5_0001 to 0x04, then read 0x04 -> each transfer 2 cycles, PRDATA=0xA5A5_0001, PSLVERR=0.
REQ-039 WAIT_CYC=3: read 0x08 -> PREADY low for 3 access cycles, high on the 4th; 5-cycle transfer total.
REQ-040 Back-to-back writes to 0x00, 0x04, 0x08 then reads -> no idle cycles, all data returned correctly.
REQ-041 Write to 0x102 (misaligned) and 0x100 (out of range) -> PSLVERR=1 with PREADY; a subsequent read of 0x00 shows it unchanged.
REQ-042 WAIT_CYC=2: PRESETn low during wait state of a write to 0x0C -> outputs 0 immediately, memory at 0x0C unchanged, next transfer completes normally.
REQ-043 PSEL deasserted mid-ACCESS on a write to 0x10 -> returns to IDLE, no PREADY pulse, 0x10 unchanged.

Source files
------------

// File: rtl/apb_slv_pkg.sv
// Shared types and default parameters for the APB slave memory.
package apb_slv_pkg;
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_DEPTH    = 64;
  localparam int DEF_WAIT_CYC = 0;
endpackage

// File: rtl/apb_slv_mem.sv
// DEPTH x DATA_W storage: synchronous write, combinational read port.
// Contents are deliberately not reset.
module apb_slv_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [DATA_W-1:0]        wr_dat,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [DATA_W-1:0]        rd_dat
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_dat;
  end

  assign rd_dat = mem[rd_idx];
endmodule

// File: rtl/apb_slave_mem.sv
// APB word-addressed memory slave; transfer takes WAIT_CYC+2 cycles.
// PREADY is held low during wait states; PSEL dropping mid-access aborts the transfer.
module apb_slave_mem
  import apb_slv_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int WAIT_CYC = DEF_WAIT_CYC
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);
  localparam int              IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH * 4);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              err_q, wr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdat_q;
  logic              setup, addr_err, mem_we;
  logic [IDX_W-1:0]  addr_idx;
  logic [DATA_W-1:0] mem_rd;

  assign addr_idx = PADDR[IDX_W+1:2];
  assign addr_err = (PADDR[1:0] != 2'b00) || ({1'b0, PADDR} >= LIMIT);
  assign setup    = (state == IDLE) && PSEL && !PENABLE;
  assign PREADY   = (state == ACCESS) && (cnt == 4'd0) && PSEL && PENABLE;
  assign PSLVERR  = PREADY && err_q;
  // Write uses the captured transfer, so bus changes during waits cannot corrupt it.
  assign mem_we   = PREADY && wr_q && !err_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (setup) begin
          state_nxt = ACCESS;
          cnt_nxt   = 4'(WAIT_CYC);
        end
      end
      ACCESS: begin
        if (!PSEL || PREADY) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      err_q  <= 1'b0;
      wr_q   <= 1'b0;
      idx_q  <= '0;
      wdat_q <= '0;
      PRDATA <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (setup) begin
        err_q  <= addr_err;
        wr_q   <= PWRITE;
        idx_q  <= addr_idx;
        wdat_q <= PWDATA;
        if (!PWRITE) PRDATA <= addr_err ? '0 : mem_rd;
      end
    end
  end

  apb_slv_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk    (PCLK),
    .wr_en  (mem_we),
    .wr_idx (idx_q),
    .wr_dat (wdat_q),
    .rd_idx (addr_idx),
    .rd_dat (mem_rd)
  );
endmodule

// File: tb/tb_apb_slave_mem.sv
// Three slaves (WAIT_CYC 0, 3, 2) on one bus; per-cycle compare against a word-array model.
module tb_apb_slave_mem;
  localparam int WC [3] = '{0, 3, 2};

  logic        PCLK, PRESETn, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [2:0]  psel, pready, pslverr;
  logic [31:0] prdata [3];

  apb_slave_mem #(.WAIT_CYC(0)) u_w0 (.PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));
  apb_slave_mem #(.WAIT_CYC(3)) u_w3 (.PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));
  apb_slave_mem #(.WAIT_CYC(2)) u_w2 (.PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[2]), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int          total = 0, bad = 0;
  logic [31:0] mdl_mem   [3][64];
  bit          mdl_known [3][64];
  bit [2:0]    exp_rdy, exp_err;
  logic [31:0] exp_dat;
  bit          dat_chk, rst_chk;
  int          cur_inst, acc_k, seen_k;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge PCLK) begin
    for (int i = 0; i < 3; i++) begin
      check("pready", 32'(pready[i]), 32'(exp_rdy[i]));
      check("pslverr", 32'(pslverr[i]), 32'(exp_err[i]));
      if (rst_chk) check("prdata_rst", prdata[i], 32'h0);
    end
    if (dat_chk && exp_rdy[cur_inst]) check("prdata", prdata[cur_inst], exp_dat);
    if (pready[cur_inst] === 1'b1 && seen_k == 0) seen_k = acc_k;
  end

  task automatic cyc();
    @(posedge PCLK);
    #1;
  endtask

  task automatic idle(input int n, input bit bogus);
    for (int i = 0; i < n; i++) begin
      cyc();
      psel    = bogus ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
      PENABLE = bogus;
      PWRITE  = 1'($urandom);
      PADDR   = $urandom;
      PWDATA  = $urandom;
      exp_rdy = '0;
      exp_err = '0;
      dat_chk = 1'b0;
      acc_k   = 0;
    end
  endtask

  // One APB transfer; abort_k / rst_k name the access cycle at which PSEL drops / reset hits (0 = never).
  task automatic xfer(input int s, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input int abort_k, input int rst_k, output int len);
    bit err, done, killed;
    int w, idx;
    w = WC[s];
    err = (addr[1:0] != 2'b00) || (addr >= 32'd256);
    idx = int'(addr[7:2]);
    done = 1'b0;
    killed = 1'b0;
    cyc();
    psel = '0; psel[s] = 1'b1;
    PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    exp_rdy = '0; exp_err = '0;
    cur_inst = s; acc_k = 0; seen_k = 0;
    dat_chk = !wr && (err || mdl_known[s][idx]);
    exp_dat = err ? 32'h0 : mdl_mem[s][idx];
    for (int k = 1; k <= w + 1 && !done; k++) begin
      cyc();
      acc_k = k;
      if (k == abort_k) begin
        psel = '0; PENABLE = 1'b0;
        exp_rdy = '0; exp_err = '0;
        killed = 1'b1; done = 1'b1;
      end else if (k == rst_k) begin
        PRESETn = 1'b0; rst_chk = 1'b1;
        exp_rdy = '0; exp_err = '0;
        cyc();
        PRESETn = 1'b1; psel = '0; PENABLE = 1'b0;
        killed = 1'b1; done = 1'b1;
      end else begin
        PENABLE = 1'b1;
        if (k <= w) begin
          PADDR = $urandom; PWDATA = $urandom;
        end else begin
          PADDR = addr; PWDATA = data;
        end
        exp_rdy = '0; exp_err = '0;
        exp_rdy[s] = (k == w + 1);
        exp_err[s] = (k == w + 1) && err;
      end
    end
    @(negedge PCLK);
    #1;
    rst_chk = 1'b0;
    len = (!killed && seen_k != 0) ? seen_k + 1 : 0;
    if (!killed && wr && !err) begin
      mdl_mem[s][idx]   = data;
      mdl_known[s][idx] = 1'b1;
    end
  endtask

  initial begin
    int len, s, ak;
    bit wr;
    logic [31:0] a;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 64; j++) mdl_known[i][j] = 1'b0;
    psel = '0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    exp_rdy = '0; exp_err = '0; dat_chk = 1'b0; cur_inst = 0; acc_k = 0; seen_k = 0;
    PRESETn = 1'b1;
    rst_chk = 1'b1;
    #1 PRESETn = 1'b0;
    cyc();
    cyc();
    PRESETn = 1'b1;
    @(negedge PCLK);
    #1 rst_chk = 1'b0;

    // Basic write/read, zero wait states
    xfer(0, 1, 32'h04, 32'hA5A5_0001, 0, 0, len); check("len_w0_wr", len, 2);
    xfer(0, 0, 32'h04, 32'h0, 0, 0, len);         check("len_w0_rd", len, 2);
    check("lit_rd_04", prdata[0], 32'hA5A5_0001);

    // Three wait states: 5-cycle transfer
    xfer(1, 1, 32'h08, 32'h0000_BEEF, 0, 0, len);
    xfer(1, 0, 32'h08, 32'h0, 0, 0, len);         check("len_w3_rd", len, 5);
    check("lit_rd_w3", prdata[1], 32'h0000_BEEF);

    // Back-to-back writes then reads
    xfer(0, 1, 32'h00, 32'h1111_1111, 0, 0, len);
    xfer(0, 1, 32'h04, 32'h2222_2222, 0, 0, len);
    xfer(0, 1, 32'h08, 32'h3333_3333, 0, 0, len);
    xfer(0, 0, 32'h00, 32'h0, 0, 0, len); check("lit_b2b_0", prdata[0], 32'h1111_1111);
    xfer(0, 0, 32'h04, 32'h0, 0, 0, len); check("lit_b2b_4", prdata[0], 32'h2222_2222);
    xfer(0, 0, 32'h08, 32'h0, 0, 0, len); check("lit_b2b_8", prdata[0], 32'h3333_3333);

    // Error responses leave memory untouched; errored read returns 0
    xfer(0, 1, 32'h102, 32'hDEAD_0102, 0, 0, len);
    xfer(0, 1, 32'h100, 32'hDEAD_0100, 0, 0, len);
    xfer(0, 0, 32'h100, 32'h0, 0, 0, len); check("lit_err_rd", prdata[0], 32'h0);
    xfer(0, 0, 32'h00, 32'h0, 0, 0, len);  check("lit_after_err", prdata[0], 32'h1111_1111);

    // Reset during a wait state of a write
    xfer(2, 1, 32'h0C, 32'hCAFE_000C, 0, 0, len);
    idle(1, 0);
    xfer(2, 1, 32'h0C, 32'hDEAD_BEEF, 0, 2, len);
    xfer(2, 0, 32'h0C, 32'h0, 0, 0, len); check("len_w2_rd", len, 4);
    check("lit_after_rst", prdata[2], 32'hCAFE_000C);

    // PSEL dropped mid-access
    xfer(0, 1, 32'h10, 32'h0000_1234, 0, 0, len);
    xfer(0, 1, 32'h10, 32'h0000_9999, 1, 0, len);
    idle(2, 1);
    xfer(0, 0, 32'h10, 32'h0, 0, 0, len); check("lit_after_abort", prdata[0], 32'h0000_1234);
    xfer(1, 1, 32'h10, 32'h0000_5678, 0, 0, len);
    xfer(1, 1, 32'h10, 32'h0000_7777, 2, 0, len);
    xfer(1, 0, 32'h10, 32'h0, 0, 0, len); check("lit_abort_w3", prdata[1], 32'h0000_5678);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      s  = $urandom_range(0, 2);
      wr = 1'($urandom);
      case ($urandom_range(0, 9))
        0:       a = {24'h0, 6'($urandom), 2'b00} + 32'($urandom_range(1, 3));
        1:       a = $urandom | 32'h100;
        default: a = 32'(4 * $urandom_range(0, 15));
      endcase
      ak = ($urandom_range(0, 9) == 0) ? $urandom_range(1, WC[s] + 1) : 0;
      xfer(s, wr, a, $urandom, ak, 0, len);
      if (ak == 0) check("len_rand", len, 32'(WC[s] + 2));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), 1'($urandom));
    end

    idle(2, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
